// File: rtl/scm_1r1w_port_arbiter_if.sv
// Requester-side bundle of the SCM port arbiter: per-port write/read requests,
// grants, and the shared read-data return.
interface scm_1r1w_port_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8,
  parameter int NUM_PORTS  = 4
);
  logic [NUM_PORTS-1:0]            wreq_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] waddr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS*NUM_BYTE-1:0]   wbe_i;
  logic [NUM_PORTS-1:0]            wgnt_o;
  logic [NUM_PORTS-1:0]            rreq_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] raddr_i;
  logic [NUM_PORTS-1:0]            rgnt_o;
  logic [NUM_PORTS-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]           rdata_o;

  modport master (
    output wreq_i, waddr_i, wdata_i, wbe_i, rreq_i, raddr_i,
    input  wgnt_o, rgnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  wreq_i, waddr_i, wdata_i, wbe_i, rreq_i, raddr_i,
    output wgnt_o, rgnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/scm_1r1w_port_arbiter_chk.sv
// Protocol checker for the SCM port arbiter: grant encoding, no reads before
// the array is initialised, and requesters holding req/payload until granted.
module scm_1r1w_port_arbiter_chk #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8,
  parameter int NUM_PORTS  = 4
) (
  input logic                            clk,
  input logic                            rst,
  input logic                            run,
  input logic [NUM_PORTS-1:0]            wreq,
  input logic [NUM_PORTS*ADDR_WIDTH-1:0] waddr,
  input logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
  input logic [NUM_PORTS*NUM_BYTE-1:0]   wbe,
  input logic [NUM_PORTS-1:0]            wgnt,
  input logic [NUM_PORTS-1:0]            rreq,
  input logic [NUM_PORTS*ADDR_WIDTH-1:0] raddr,
  input logic [NUM_PORTS-1:0]            rgnt
);
  a_wgnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(wgnt));
  a_rgnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rgnt));
  a_no_rgnt_init: assert property (@(posedge clk) disable iff (rst) !run |-> (rgnt == {NUM_PORTS{1'b0}}));

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_hold
    a_wreq_hold: assert property (@(posedge clk) disable iff (rst)
      (wreq[p] && !wgnt[p]) |=> (wreq[p]
        && $stable(waddr[p*ADDR_WIDTH +: ADDR_WIDTH])
        && $stable(wdata[p*DATA_WIDTH +: DATA_WIDTH])
        && $stable(wbe[p*NUM_BYTE +: NUM_BYTE])));
    a_rreq_hold: assert property (@(posedge clk) disable iff (rst)
      (rreq[p] && !rgnt[p]) |=> (rreq[p] && $stable(raddr[p*ADDR_WIDTH +: ADDR_WIDTH])));
  end
endmodule

// File: rtl/scm_1r1w_port_arbiter.sv
// Round-robin arbiter placing NUM_PORTS writers and NUM_PORTS readers onto one
// 1R1W latch SCM; zero-fills the array after reset and holds off colliding reads.
module scm_1r1w_port_arbiter #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_BYTE      = DATA_WIDTH / 8,
  parameter int NUM_PORTS     = 4,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  scm_1r1w_port_arbiter_if.slave req_if,
  output logic                  init_done_o,
  output logic                  scm_re_o,
  output logic [ADDR_WIDTH-1:0] scm_raddr_o,
  input  logic [DATA_WIDTH-1:0] scm_rdata_i,
  output logic                  scm_we_o,
  output logic [ADDR_WIDTH-1:0] scm_waddr_o,
  output logic [DATA_WIDTH-1:0] scm_wdata_o,
  output logic [NUM_BYTE-1:0]   scm_wbe_o
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RESET = INIT_ON_RESET ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = ADDR_WIDTH'(1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_PORTS - 1);

  // {found, index} of the first requester at or after ptr, wrapping upward.
  function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req, input logic [PW-1:0] ptr);
    logic          found;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    int            k;
    found = 1'b0;
    win   = ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k   = (int'(ptr) + i) % NUM_PORTS;
      idx = PW'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? PTR_ZERO : p + PTR_ONE;
  endfunction

  logic [0:0]            state_r;
  logic [ADDR_WIDTH-1:0] init_cnt_r;
  logic [PW-1:0]         wptr_r;
  logic [PW-1:0]         rptr_r;
  logic [NUM_PORTS-1:0]  rvalid_r;

  logic                  run_s;
  logic [PW:0]           wpick_s;
  logic [PW:0]           rpick_s;
  logic [PW-1:0]         w_win_s;
  logic [PW-1:0]         r_win_s;
  logic                  w_go_s;
  logic                  r_go_s;
  logic                  hazard_s;
  logic [ADDR_WIDTH-1:0] w_addr_s;
  logic [ADDR_WIDTH-1:0] r_addr_s;
  logic [DATA_WIDTH-1:0] w_data_s;
  logic [NUM_BYTE-1:0]   w_be_s;
  logic [NUM_PORTS-1:0]  wgnt_s;
  logic [NUM_PORTS-1:0]  rgnt_s;

  assign run_s = (state_r == ST_RUN);

  // Both round-robin picks; a read hitting the granted write address is held, not substituted.
  always_comb begin
    wpick_s  = rr_pick(req_if.wreq_i, wptr_r);
    w_win_s  = wpick_s[PW-1:0];
    w_go_s   = run_s & wpick_s[PW];
    w_addr_s = req_if.waddr_i[w_win_s*ADDR_WIDTH +: ADDR_WIDTH];
    w_data_s = req_if.wdata_i[w_win_s*DATA_WIDTH +: DATA_WIDTH];
    w_be_s   = req_if.wbe_i[w_win_s*NUM_BYTE +: NUM_BYTE];
    rpick_s  = rr_pick(req_if.rreq_i, rptr_r);
    r_win_s  = rpick_s[PW-1:0];
    r_addr_s = req_if.raddr_i[r_win_s*ADDR_WIDTH +: ADDR_WIDTH];
    hazard_s = w_go_s & (r_addr_s == w_addr_s);
    r_go_s   = run_s & rpick_s[PW] & ~hazard_s;
    wgnt_s   = {NUM_PORTS{1'b0}};
    rgnt_s   = {NUM_PORTS{1'b0}};
    if (w_go_s) begin
      wgnt_s[w_win_s] = 1'b1;
    end else begin
      wgnt_s = {NUM_PORTS{1'b0}};
    end
    if (r_go_s) begin
      rgnt_s[r_win_s] = 1'b1;
    end else begin
      rgnt_s = {NUM_PORTS{1'b0}};
    end
  end

  // SCM port drive: zero-fill sweep during INIT, granted payloads during RUN.
  always_comb begin
    scm_re_o    = r_go_s;
    scm_raddr_o = r_addr_s;
    if (run_s) begin
      scm_we_o    = w_go_s;
      scm_waddr_o = w_addr_s;
      scm_wdata_o = w_data_s;
      scm_wbe_o   = w_be_s;
    end else begin
      scm_we_o    = 1'b1;
      scm_waddr_o = init_cnt_r;
      scm_wdata_o = {DATA_WIDTH{1'b0}};
      scm_wbe_o   = {NUM_BYTE{1'b1}};
    end
  end

  // FSM, init counter, round-robin pointers and the one-cycle read-valid pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RESET;
      init_cnt_r <= {ADDR_WIDTH{1'b0}};
      wptr_r     <= PTR_ZERO;
      rptr_r     <= PTR_ZERO;
      rvalid_r   <= {NUM_PORTS{1'b0}};
    end else begin
      if (!run_s) begin
        init_cnt_r <= init_cnt_r + CNT_ONE;
        if (init_cnt_r == LAST_ADDR) begin
          state_r <= ST_RUN;
        end
      end
      if (w_go_s) begin
        wptr_r <= ptr_after(w_win_s);
      end
      if (r_go_s) begin
        rptr_r <= ptr_after(r_win_s);
      end
      rvalid_r <= rgnt_s;
    end
  end

  assign init_done_o     = run_s;
  assign req_if.wgnt_o   = wgnt_s;
  assign req_if.rgnt_o   = rgnt_s;
  assign req_if.rvalid_o = rvalid_r;
  assign req_if.rdata_o  = scm_rdata_i;

  scm_1r1w_port_arbiter_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_BYTE   (NUM_BYTE),
    .NUM_PORTS  (NUM_PORTS)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .run   (run_s),
    .wreq  (req_if.wreq_i),
    .waddr (req_if.waddr_i),
    .wdata (req_if.wdata_i),
    .wbe   (req_if.wbe_i),
    .wgnt  (wgnt_s),
    .rreq  (req_if.rreq_i),
    .raddr (req_if.raddr_i),
    .rgnt  (rgnt_s)
  );
endmodule

// File: tb/tb_scm_1r1w_port_arbiter.sv
// Scoreboard bench for scm_1r1w_port_arbiter with a behavioural 1R1W SCM behind it.
module tb_scm_1r1w_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int NP = 4;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scm_1r1w_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB), .NUM_PORTS(NP)) bus ();

  logic          init_done, scm_re, scm_we;
  logic [AW-1:0] scm_raddr, scm_waddr;
  logic [DW-1:0] scm_rdata, scm_wdata;
  logic [NB-1:0] scm_wbe;

  scm_1r1w_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB), .NUM_PORTS(NP), .INIT_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .req_if(bus), .init_done_o(init_done),
    .scm_re_o(scm_re), .scm_raddr_o(scm_raddr), .scm_rdata_i(scm_rdata),
    .scm_we_o(scm_we), .scm_waddr_o(scm_waddr), .scm_wdata_o(scm_wdata), .scm_wbe_o(scm_wbe)
  );

  // Behavioural SCM: prefilled with a pattern so the zero-fill is observable.
  logic [DW-1:0] scm_mem [DEPTH];
  logic          scm_fill;
  always @(posedge clk) begin
    if (scm_fill) begin
      for (int k = 0; k < DEPTH; k++) scm_mem[k] <= 32'hA5A5_A5A5;
    end else if (scm_we) begin
      for (int b = 0; b < NB; b++)
        if (scm_wbe[b]) scm_mem[scm_waddr][8*b +: 8] <= scm_wdata[8*b +: 8];
    end
    if (scm_re) scm_rdata <= scm_mem[scm_raddr];
  end

  int n_total = 0;
  int n_bad   = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  logic [NP-1:0] wreq, rreq;
  logic [AW-1:0] wa [NP];
  logic [AW-1:0] ra [NP];
  logic [DW-1:0] wd [NP];
  logic [NB-1:0] wb [NP];
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct { int port; logic [DW-1:0] data; int due; } rd_exp_t;
  rd_exp_t sb[$];

  task automatic drive();
    bus.wreq_i = wreq;
    bus.rreq_i = rreq;
    for (int p = 0; p < NP; p++) begin
      bus.waddr_i[p*AW +: AW] = wa[p];
      bus.wdata_i[p*DW +: DW] = wd[p];
      bus.wbe_i[p*NB +: NB]   = wb[p];
      bus.raddr_i[p*AW +: AW] = ra[p];
    end
  endtask

  task automatic clear_ref();
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h0;
  endtask

  // One RUN cycle: drive, check grants/SCM ports at negedge, update model, retire granted reqs.
  task automatic run_cycle(input logic [NP-1:0] ew, input logic [NP-1:0] er, input bit keep_w);
    drive();
    @(negedge clk);
    chk("wgnt", bus.wgnt_o, ew);
    chk("rgnt", bus.rgnt_o, er);
    chk("init_done", init_done, 1);
    chk("scm_we", scm_we, ew != 0);
    chk("scm_re", scm_re, er != 0);
    for (int p = 0; p < NP; p++) begin
      if (ew[p]) begin
        chk("scm_waddr", scm_waddr, wa[p]);
        chk("scm_wpayload", {scm_wdata, scm_wbe}, {wd[p], wb[p]});
        for (int b = 0; b < NB; b++)
          if (wb[p][b]) ref_mem[wa[p]][8*b +: 8] = wd[p][8*b +: 8];
        if (!keep_w) wreq[p] = 1'b0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (er[p]) begin
        chk("scm_raddr", scm_raddr, ra[p]);
        sb.push_back('{port: p, data: ref_mem[ra[p]], due: cyc_cnt + 1});
        rreq[p] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [NP-1:0] ew, input logic [NP-1:0] er, input bit keep_w);
    run_cycle(ew, er, keep_w);
    @(posedge clk); #1;
  endtask

  task automatic init_walk(input int n);
    for (int k = 0; k < n; k++) begin
      drive();
      @(negedge clk);
      chk("init_waddr", scm_waddr, k);
      chk("init_we", scm_we, 1);
      chk("init_fill", {scm_wdata, scm_wbe, scm_re}, {32'h0, 4'hF, 1'b0});
      chk("init_gnt", {bus.wgnt_o, bus.rgnt_o}, 0);
      chk("init_done_lo", init_done, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic mon();
    rd_exp_t e;
    logic [NP-1:0] m;
    if (!rst && bus.rvalid_o != '0) begin
      if (sb.size() == 0) begin
        chk("rvalid_spurious", bus.rvalid_o, 0);
      end else begin
        e = sb.pop_front();
        m = '0;
        m[e.port] = 1'b1;
        chk("rvalid_port", bus.rvalid_o, m);
        chk("rvalid_cycle", cyc_cnt, e.due);
        chk("rdata", bus.rdata_o, e.data);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon();
    end
  end

  initial begin
    rst = 1'b1;
    scm_fill = 1'b1;
    wreq = 4'hF;
    rreq = 4'b0001;
    for (int p = 0; p < NP; p++) begin
      wa[p] = AW'(16 + p);
      wd[p] = 32'hC0DE_0000 + DW'(p);
      wb[p] = 4'hF;
      ra[p] = 5'd7;
    end
    clear_ref();
    drive();
    @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_rvalid", bus.rvalid_o, 0);
    chk("rst_wgnt", bus.wgnt_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    scm_fill = 1'b0;

    // Init sweep, then all writers held high: grants rotate 0,1,2,3,0,...; port 0 reads addr 7.
    init_walk(DEPTH);
    for (int i = 0; i < 8; i++)
      step(4'(1 << (i % 4)), (i == 0) ? 4'b0001 : 4'b0000, i < 4);

    // Write then read the same address on consecutive cycles.
    wa[1] = 5'd5; wd[1] = 32'hDEAD_BEEF; wreq[1] = 1'b1;
    step(4'b0010, 4'b0000, 0);
    ra[3] = 5'd5; rreq[3] = 1'b1;
    step(4'b0000, 4'b1000, 0);
    step(4'b0000, 4'b0000, 0);

    // Hazard: same-address read waits one cycle; different address proceeds.
    wa[0] = 5'd9; wd[0] = 32'h9999_0000; wreq[0] = 1'b1;
    ra[2] = 5'd9; rreq[2] = 1'b1;
    step(4'b0001, 4'b0000, 0);
    step(4'b0000, 4'b0100, 0);
    wa[1] = 5'd9; wd[1] = 32'h5555_AAAA; wreq[1] = 1'b1;
    ra[2] = 5'd10; rreq[2] = 1'b1;
    step(4'b0010, 4'b0100, 0);
    // Blocked candidate is not replaced by another waiting reader.
    wa[0] = 5'd12; wd[0] = 32'h1212_1212; wreq[0] = 1'b1;
    ra[3] = 5'd12; rreq[3] = 1'b1;
    ra[1] = 5'd13; rreq[1] = 1'b1;
    step(4'b0001, 4'b0000, 0);
    step(4'b0000, 4'b1000, 0);
    step(4'b0000, 4'b0010, 0);

    // Byte enables, including an all-zero mask that still consumes a grant.
    wa[2] = 5'd0; wd[2] = 32'h1122_3344; wb[2] = 4'b0101; wreq[2] = 1'b1;
    step(4'b0100, 4'b0000, 0);
    ra[0] = 5'd0; rreq[0] = 1'b1;
    step(4'b0000, 4'b0001, 0);
    wa[3] = 5'd0; wd[3] = 32'hFFFF_FFFF; wb[3] = 4'b0000; wreq[3] = 1'b1;
    step(4'b1000, 4'b0000, 0);
    rreq[0] = 1'b1;
    step(4'b0000, 4'b0001, 0);

    // Reset with a read outstanding: its rvalid must never appear.
    wa[1] = 5'd20; wd[1] = 32'h2020_2020; wb[1] = 4'hF; wreq[1] = 1'b1;
    ra[1] = 5'd21; rreq[1] = 1'b1;
    run_cycle(4'b0010, 4'b0010, 0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("rst_drop_rvalid", bus.rvalid_o, 0);
    chk("rst_done_lo", init_done, 0);
    rst = 1'b0;

    // Reset again at init count 12: sweep restarts from address 0.
    init_walk(12);
    @(negedge clk);
    chk("init_waddr12", scm_waddr, 12);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    init_walk(DEPTH);
    clear_ref();

    // Pointers back at 0: ports 1 and 3 requesting on both sides -> 1 first.
    wa[1] = 5'd24; wd[1] = 32'hAAAA_0001; wb[1] = 4'hF;
    wa[3] = 5'd25; wd[3] = 32'hAAAA_0003; wb[3] = 4'hF;
    wreq = 4'b1010;
    ra[1] = 5'd20; ra[3] = 5'd21; rreq = 4'b1010;
    step(4'b0010, 4'b0010, 0);
    step(4'b1000, 4'b1000, 0);
    wa[2] = 5'd26; wd[2] = 32'hAAAA_0002; wb[2] = 4'hF; wreq[2] = 1'b1;
    step(4'b0100, 4'b0000, 0);
    step(4'b0000, 4'b0000, 0);
    step(4'b0000, 4'b0000, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
